// File: rtl/up_down_counter_3to12.sv
// Bounded up/down modulo counter over [MIN_VAL, MAX_VAL].
// Synchronous reset, parallel load with clamp, wrap at both ends.
module up_down_counter_3to12 #(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 3,
    parameter int MAX_VAL = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] MIN_Q = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             below_min;
    logic             above_max;
    logic             at_min;
    logic             at_max;

    // Range flags for the current state; out-of-range values recover on count.
    always_comb begin
        below_min = (count_q < MIN_Q);
        above_max = (count_q > MAX_Q);
        at_min    = (count_q == MIN_Q);
        at_max    = (count_q == MAX_Q);
    end

    // Next count: reset beats load, load beats counting.
    always_comb begin
        count_d = count_q;
        if (reset) begin
            count_d = MIN_Q;
        end else if (load) begin
            if (d < MIN_Q) begin
                count_d = MIN_Q;
            end else if (d > MAX_Q) begin
                count_d = MAX_Q;
            end else begin
                count_d = d;
            end
        end else if (up_down) begin
            if (at_max || above_max || below_min) begin
                count_d = MIN_Q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else begin
            if (at_min || below_min || above_max) begin
                count_d = MAX_Q;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign q = count_q;

endmodule

// File: tb/tb_up_down_counter_3to12.sv
// Bench for up_down_counter_3to12: arithmetic model checked every cycle
// plus directed vectors with literal expectations.
module tb_up_down_counter_3to12;

    localparam int LO   = 3;
    localparam int HI   = 12;
    localparam int SPAN = HI - LO + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       up_down = 1'b1;
    logic       load = 1'b0;
    logic [3:0] d = 4'd0;
    logic [3:0] q;

    int vectors = 0;
    int errors  = 0;
    int model   = 0;
    bit model_ok = 1'b0;

    up_down_counter_3to12 dut (
        .clk     (clk),
        .reset   (reset),
        .up_down (up_down),
        .load    (load),
        .d       (d),
        .q       (q)
    );

    always #5 clk = ~clk;

    function automatic int next_val(int cur, bit r, bit l, bit ud, int dv);
        if (r) return LO;
        if (l) return (dv < LO) ? LO : ((dv > HI) ? HI : dv);
        if (ud) return (cur - LO + 1) % SPAN + LO;
        return (cur - LO + SPAN - 1) % SPAN + LO;
    endfunction

    // Reference model advances on the same edge as the DUT.
    always @(posedge clk) begin
        if (reset) begin
            model    <= LO;
            model_ok <= 1'b1;
        end else if (model_ok) begin
            model <= next_val(model, 1'b0, load, up_down, int'(d));
        end
    end

    // Every-cycle comparison against the model once reset has been seen.
    always @(negedge clk) begin
        if (model_ok) begin
            vectors++;
            if (q !== 4'(model)) begin
                errors++;
                $display("FAIL model_cmp t=%0t q=%0d expected=%0d",
                         $time, q, model);
            end
        end
    end

    task automatic step(input bit r, input bit l, input bit ud,
                        input int dv, input int exp, input string nm);
        reset   = r;
        load    = l;
        up_down = ud;
        d       = 4'(dv);
        @(posedge clk);
        #1;
        if (exp >= 0) begin
            vectors++;
            if (q !== 4'(exp)) begin
                errors++;
                $display("FAIL %s q=%0d expected=%0d", nm, q, exp);
            end
        end
    endtask

    initial begin
        #2;
        step(1, 0, 1, 0, 3, "reset");
        step(1, 1, 1, 9, 3, "reset_over_load");

        for (int i = 0; i < 20; i++)
            step(0, 0, 1, 0, ((i + 1) % 10) + 3, "up_wrap");

        for (int i = 0; i < 11; i++)
            step(0, 0, 0, 0, 12 - (i % 10), "down_wrap");

        step(0, 1, 1, 7, 7, "load_prio");
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 0, 8 + i, "after_load");

        step(0, 1, 0, 5, 5, "load_over_down");
        step(0, 0, 0, 0, 4, "down_from_load");

        step(0, 1, 1, 1, 3, "clamp_lo");
        step(0, 1, 1, 0, 3, "clamp_zero");
        step(0, 1, 1, 2, 3, "clamp_two");
        step(0, 1, 1, 15, 12, "clamp_hi");
        step(0, 1, 1, 13, 12, "clamp_13");
        step(0, 1, 1, 12, 12, "load_max");
        step(0, 0, 1, 0, 3, "max_up_wrap");
        step(0, 1, 0, 3, 3, "load_min");
        step(0, 0, 0, 0, 12, "min_down_wrap");

        step(0, 1, 1, 9, 9, "load_9");
        step(1, 0, 1, 0, 3, "mid_reset");
        step(0, 0, 1, 0, 4, "post_reset_up");
        step(0, 0, 1, 0, 5, "up_to_5");
        step(0, 0, 0, 0, 4, "dir_flip");
        step(0, 0, 0, 0, 3, "down_to_3");

        step(1, 0, 0, 0, 3, "reset_again");
        step(0, 0, 0, 0, 12, "post_reset_down");

        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 -1, "rand");

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
